// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus widths.
package apb_pkg;

  localparam int APB_AW_DEF = 32;
  localparam int APB_DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_bus_master_if.sv
// Request/response handshake plus APB bus bundle for apb_bus_master.
interface apb_bus_master_if
  import apb_pkg::*;
#(
  parameter int AW = APB_AW_DEF,
  parameter int DW = APB_DW_DEF
);

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_write;

  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pwrite;
  logic          psel;
  logic          penable;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    input  req_valid, req_addr, req_wdata, req_write,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_write,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_timeout_counter.sv
// ACCESS-phase wait counter; expired pulses on the tick that
// completes the TIMEOUT_CYCLES-th stalled cycle.
module apb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired = tick &&
    (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/apb_bus_master.sv
// Single-outstanding APB requester: valid/ready command in, response out.
// Optional ACCESS timeout enabled by defining APB_TIMEOUT_EN.
module apb_bus_master
  import apb_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = APB_AW_DEF,
  parameter int APB_DATA_WIDTH = APB_DW_DEF,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic             pclk,
  input logic             presetn,
  apb_bus_master_if.master bus
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_e                state_q;
  logic                      req_ready_q;
  logic                      resp_valid_q;
  logic [APB_DATA_WIDTH-1:0] resp_rdata_q;
  logic                      resp_err_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      pwrite_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      tmo_expired;

`ifdef APB_TIMEOUT_EN
  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (pclk),
    .rst_n   (presetn),
    .clear   (state_q == SETUP),
    .tick    ((state_q == ACCESS) && !bus.pready),
    .expired (tmo_expired)
  );
`else
  assign tmo_expired = 1'b0;
`endif

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pwrite_q     <= 1'b0;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            paddr_q     <= bus.req_addr;
            pwdata_q    <= bus.req_wdata;
            pwrite_q    <= bus.req_write;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // pready wins over a timeout landing on the same edge
          if (bus.pready) begin
            resp_rdata_q <= pwrite_q ? '0 : bus.prdata;
            resp_err_q   <= bus.pslverr;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else if (tmo_expired) begin
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.paddr      = paddr_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.psel       = psel_q;
  assign bus.penable    = penable_q;

endmodule

// File: tb/tb_apb_bus_master.sv
// Bench for apb_bus_master: vector table plus random transfers against
// a latency/data model, and reset/timeout sequences.
module tb_apb_bus_master;

  localparam int TMO = 8;
`ifdef APB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    bit          slverr;
    int          rdelay;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  apb_bus_master_if #(.AW(32), .DW(32)) bus ();

  apb_bus_master #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, logic [31:0] a,
      logic [31:0] wd, logic [31:0] rd, int ws, bit se,
      int rdl, logic [31:0] er, bit ee, int el);
    vec_t v;
    v.write = w; v.addr = a; v.wdata = wd; v.prdata = rd;
    v.waits = ws; v.slverr = se; v.rdelay = rdl;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  // Expected result from the transfer rules alone
  function automatic vec_t model(vec_t v);
    vec_t m = v;
    if (TMO_EN && v.waits >= TMO) begin
      m.exp_rdata = '0;
      m.exp_err   = 1'b1;
      m.exp_lat   = 2 + TMO;
    end else begin
      m.exp_rdata = v.write ? 32'h0 : v.prdata;
      m.exp_err   = v.slverr;
      m.exp_lat   = 3 + v.waits;
    end
    return m;
  endfunction

  task automatic do_txn(input vec_t v);
    int lat;
    int acc;
    bit done;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      if (bus.req_ready === 1'b1) ok = 1'b1;
      else begin @(posedge pclk); @(negedge pclk); end
    end
    chk("req_ready_idle", 64'(ok), 64'd1);
    if (!ok) return;
    bus.req_valid = 1'b1;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    bus.req_write = v.write;
    @(posedge pclk); @(negedge pclk);
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_write = 1'($urandom);
    chk("setup_ctl", {bus.psel, bus.penable, bus.req_ready},
        3'b100);
    chk("setup_paddr", bus.paddr, v.addr);
    chk("setup_pwrite", bus.pwrite, v.write);
    if (v.write) chk("setup_pwdata", bus.pwdata, v.wdata);
    lat = 1; acc = 0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (bus.resp_valid === 1'b1) done = 1'b1;
      else begin
        if (bus.psel === 1'b1 && bus.penable === 1'b1) begin
          chk("access_stable", {bus.paddr, bus.pwrite},
              {v.addr, v.write});
          bus.pready  = (acc == v.waits);
          bus.prdata  = (acc == v.waits) ? v.prdata : $urandom;
          bus.pslverr = (acc == v.waits) ? v.slverr
                                         : 1'($urandom);
          acc++;
        end else begin
          bus.pready  = 1'($urandom);
          bus.prdata  = $urandom;
          bus.pslverr = 1'($urandom);
        end
        @(posedge pclk); lat++; @(negedge pclk);
      end
    end
    chk("resp_arrived", 64'(done), 64'd1);
    if (!done) return;
    bus.pready  = 1'($urandom);
    bus.prdata  = $urandom;
    bus.pslverr = 1'($urandom);
    chk("resp_latency", 64'(lat), 64'(v.exp_lat));
    chk("resp_rdata", bus.resp_rdata, v.exp_rdata);
    chk("resp_err", bus.resp_err, v.exp_err);
    chk("resp_bus_idle", {bus.psel, bus.penable, bus.req_ready},
        3'b000);
    for (int k = 0; k < v.rdelay; k++) begin
      @(posedge pclk); @(negedge pclk);
      bus.pready  = 1'($urandom);
      bus.pslverr = 1'($urandom);
      bus.prdata  = $urandom;
      chk("resp_hold",
          {bus.resp_valid, bus.resp_rdata, bus.resp_err,
           bus.req_ready, bus.psel},
          {1'b1, v.exp_rdata, v.exp_err, 2'b00});
    end
    bus.resp_ready = 1'b1;
    @(posedge pclk); @(negedge pclk);
    bus.resp_ready = 1'b0;
    bus.pready = 1'b0;
    chk("resp_done", {bus.resp_valid, bus.req_ready}, 2'b01);
    chk("idle_paddr_kept", bus.paddr, v.addr);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t r;

    bus.req_valid = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0;   bus.req_write = 1'b0;
    bus.resp_ready = 1'b0;
    bus.prdata = '0; bus.pready = 1'b0; bus.pslverr = 1'b0;

    tbl.push_back(mk(1, 32'h1A10_0004, 32'hDEAD_BEEF,
                     32'hCAFE_0000, 0, 0, 0, 32'h0, 0, 3));
    tbl.push_back(mk(0, 32'h1A10_0008, 32'h0,
                     32'h1234_5678, 2, 0, 0, 32'h1234_5678, 0, 5));
    tbl.push_back(mk(0, 32'h0000_0040, 32'h0,
                     32'hA5A5_A5A5, 1, 1, 0, 32'hA5A5_A5A5, 1, 4));
    tbl.push_back(mk(1, 32'h0000_0080, 32'h5555_AAAA,
                     32'h0F0F_0F0F, 0, 0, 4, 32'h0, 0, 3));
    tbl.push_back(mk(1, 32'hFFFF_FFFC, 32'h1111_2222,
                     32'h3333_4444, 0, 1, 1, 32'h0, 1, 3));
`ifdef APB_TIMEOUT_EN
    tbl.push_back(mk(0, 32'h0000_0100, 32'h0,
                     32'h7777_8888, TMO - 1, 0, 0,
                     32'h7777_8888, 0, 2 + TMO));
    tbl.push_back(mk(0, 32'h0000_0104, 32'h0,
                     32'h9999_AAAA, 100, 0, 0, 32'h0, 1, 2 + TMO));
`endif
    for (int i = 0; i < 20; i++) begin
      r.write  = 1'($urandom);
      r.addr   = $urandom;
      r.wdata  = $urandom;
      r.prdata = $urandom;
      r.waits  = int'($urandom_range(0, 5));
      r.slverr = ($urandom_range(0, 3) == 0);
      r.rdelay = int'($urandom_range(0, 3));
      tbl.push_back(model(r));
    end

    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_ctl", {bus.psel, bus.penable, bus.pwrite,
                    bus.req_ready, bus.resp_valid, bus.resp_err},
        6'b0);
    chk("rst_paddr", bus.paddr, 32'h0);
    chk("rst_pwdata", bus.pwdata, 32'h0);
    chk("rst_rdata", bus.resp_rdata, 32'h0);
    presetn = 1'b1;
    @(posedge pclk); @(negedge pclk);
    chk("rst_release_ready", bus.req_ready, 1'b1);

    foreach (tbl[i]) do_txn(tbl[i]);

    // Reset pulse while the slave stalls in ACCESS
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h2000_0010;
    bus.req_write = 1'b0;
    bus.pready    = 1'b0;
    @(posedge pclk); @(negedge pclk);
    bus.req_valid = 1'b0;
    @(posedge pclk); @(negedge pclk);
    chk("midrst_in_access", {bus.psel, bus.penable}, 2'b11);
    presetn = 1'b0;
    @(posedge pclk); @(negedge pclk);
    chk("midrst_bus_idle", {bus.psel, bus.penable,
                            bus.resp_valid, bus.req_ready},
        4'b0000);
    @(posedge pclk); @(negedge pclk);
    chk("midrst_hold_ready", bus.req_ready, 1'b0);
    presetn = 1'b1;
    @(posedge pclk); @(negedge pclk);
    chk("midrst_release_ready", bus.req_ready, 1'b1);
    chk("midrst_no_resp", bus.resp_valid, 1'b0);

    do_txn(mk(0, 32'h3000_0000, 32'h0, 32'hBEEF_0001,
              1, 0, 0, 32'hBEEF_0001, 0, 4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
